// File: rtl/llg3_timer_unit_if.sv
// Nibble-wide Saturn bus window for one timer unit.
// The bus master drives strobes, offset and write data; the timer returns registered read data.
interface llg3_timer_unit_if;
  logic       read_in;
  logic       write_in;
  logic [3:0] addr_in;
  logic [3:0] data_in;
  logic [3:0] data_o;

  modport master (output read_in, write_in, addr_in, data_in, input data_o);
  modport slave  (input read_in, write_in, addr_in, data_in, output data_o);
endinterface

// File: rtl/llg3_timer_unit.sv
// Memory-mapped countdown timer: decrements on each 512 Hz strobe while running,
// and flags underflow through a gated, registered level interrupt.
module llg3_timer_unit #(
  parameter int unsigned CNT_NIBBLES = 5
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    clk_512Hz_in,
  input  logic                    irq_enabled_in,
  llg3_timer_unit_if.slave        bus,
  output logic                    irq_o
);
  localparam int unsigned CW       = 4 * CNT_NIBBLES;
  localparam logic [3:0]  CTRL_OFS = 4'h8;
  localparam logic [3:0]  CNT_BASE = 4'h9;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-5:0] snap_q, snap_d;
  logic          run_q, run_d;
  logic          ie_q, ie_d;
  logic          uf_q, uf_d;
  logic [3:0]    data_q, data_d;
  logic          irq_q, irq_d;
  logic          tick;

  // Any write, mapped or not, swallows a coincident tick completely.
  assign tick = clk_512Hz_in & run_q & ~bus.write_in;

  always_comb begin
    cnt_d  = cnt_q;
    snap_d = snap_q;
    run_d  = run_q;
    ie_d   = ie_q;
    uf_d   = uf_q;
    data_d = '0;
    irq_d  = uf_q & ie_q & irq_enabled_in;

    if (tick) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        uf_d = 1'b1;
      end
    end

    if (bus.write_in) begin
      if (bus.addr_in == CTRL_OFS) begin
        run_d = bus.data_in[0];
        ie_d  = bus.data_in[1];
        if (!bus.data_in[2]) begin
          uf_d = 1'b0;
        end
      end
      for (int unsigned i = 0; i < CNT_NIBBLES; i++) begin
        if (bus.addr_in == 4'(CNT_BASE + i)) begin
          cnt_d[i*4 +: 4] = bus.data_in;
        end
      end
    end

    // Only the upper nibbles are snapshotted; offset 0x9 itself always reads live.
    if (bus.read_in && bus.addr_in == CNT_BASE) begin
      snap_d = cnt_q[CW-1:4];
    end

    if (bus.addr_in == CTRL_OFS) begin
      data_d = {1'b0, uf_q, ie_q, run_q};
    end else if (bus.addr_in == CNT_BASE) begin
      data_d = cnt_q[3:0];
    end else begin
      for (int unsigned i = 1; i < CNT_NIBBLES; i++) begin
        if (bus.addr_in == 4'(CNT_BASE + i)) begin
          data_d = snap_q[(i-1)*4 +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
      run_q  <= 1'b0;
      ie_q   <= 1'b0;
      uf_q   <= 1'b0;
      data_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      run_q  <= run_d;
      ie_q   <= ie_d;
      uf_q   <= uf_d;
      data_q <= data_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.data_o = data_q;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_llg3_timer_unit.sv
// Directed bench for llg3_timer_unit: reset, countdown, underflow/IRQ, snapshot,
// tick/write collision, gating and simultaneous read/write.
module tb_llg3_timer_unit;
  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;
  logic clk_512Hz_in = 1'b0;
  logic irq_enabled_in = 1'b0;
  logic irq_o;
  int   n_assert = 0;
  int   n_fail = 0;

  llg3_timer_unit_if bus ();

  llg3_timer_unit #(.CNT_NIBBLES(5)) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .clk_512Hz_in   (clk_512Hz_in),
    .irq_enabled_in (irq_enabled_in),
    .bus            (bus),
    .irq_o          (irq_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    bus.write_in = 1'b1; bus.addr_in = a; bus.data_in = d;
    cyc();
    bus.write_in = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] exp, input string tag);
    bus.read_in = 1'b1; bus.addr_in = a;
    cyc();
    bus.read_in = 1'b0;
    chk(tag, {16'h0, bus.data_o}, {16'h0, exp});
  endtask

  task automatic tick();
    clk_512Hz_in = 1'b1;
    cyc();
    clk_512Hz_in = 1'b0;
  endtask

  task automatic wcnt(input logic [19:0] v);
    for (int i = 0; i < 5; i++) wr(4'(9 + i), v[i*4 +: 4]);
  endtask

  task automatic readcnt(input logic [19:0] exp, input string tag);
    for (int i = 0; i < 5; i++) rd(4'(9 + i), exp[i*4 +: 4], tag);
  endtask

  initial begin
    bus.read_in = 1'b0; bus.write_in = 1'b0; bus.addr_in = 4'h0; bus.data_in = 4'h0;

    // Reset state
    #1;
    chk("reset_data", {16'h0, bus.data_o}, 20'h0);
    chk("reset_irq", {19'h0, irq_o}, 20'h0);
    #12 reset_n_in = 1'b1;
    cyc();
    rd(4'h8, 4'h0, "reset_ctrl");
    readcnt(20'h0, "reset_cnt");

    // Countdown 3 -> 0 without underflow
    wcnt(20'h00003);
    wr(4'h8, 4'h1);
    tick(); tick(); tick();
    readcnt(20'h00000, "countdown_cnt");
    rd(4'h8, 4'h1, "countdown_ctrl");

    // Underflow with IRQ
    irq_enabled_in = 1'b1;
    wr(4'h8, 4'h3);
    tick();
    chk("uf_irq_latency", {19'h0, irq_o}, 20'h0);
    cyc();
    chk("uf_irq_high", {19'h0, irq_o}, 20'h1);
    readcnt(20'hFFFFF, "uf_wrap");
    rd(4'h8, 4'h7, "uf_ctrl");
    wr(4'h8, 4'h3);
    cyc();
    chk("uf_irq_cleared", {19'h0, irq_o}, 20'h0);
    rd(4'h8, 4'h3, "uf_clear_ctrl");

    // Underflow with global gate off, then gate on, then IE off with UF kept
    irq_enabled_in = 1'b0;
    wcnt(20'h0);
    tick();
    cyc(); cyc();
    chk("gate_off_irq", {19'h0, irq_o}, 20'h0);
    rd(4'h8, 4'h7, "gate_off_ctrl");
    irq_enabled_in = 1'b1;
    cyc(); cyc();
    chk("gate_on_irq", {19'h0, irq_o}, 20'h1);
    wr(4'h8, 4'h4);
    cyc();
    chk("ie_off_irq", {19'h0, irq_o}, 20'h0);
    rd(4'h8, 4'h4, "uf_kept_ctrl");
    wr(4'h8, 4'h0);
    rd(4'h8, 4'h0, "uf_clr_ctrl");

    // Snapshot coherence across a tick
    wcnt(20'h10000);
    wr(4'h8, 4'h1);
    rd(4'h9, 4'h0, "snap_lsn");
    tick();
    rd(4'hA, 4'h0, "snap_a");
    rd(4'hB, 4'h0, "snap_b");
    rd(4'hC, 4'h0, "snap_c");
    rd(4'hD, 4'h1, "snap_d");
    rd(4'h9, 4'hF, "snap_live");
    readcnt(20'h0FFFF, "snap_live_cnt");

    // Tick collides with a write: write wins, no decrement
    wr(4'h8, 4'h0);
    wcnt(20'h00005);
    wr(4'h8, 4'h1);
    clk_512Hz_in = 1'b1;
    wr(4'h9, 4'hA);
    clk_512Hz_in = 1'b0;
    readcnt(20'h0000A, "collide_cnt");
    clk_512Hz_in = 1'b1;
    wr(4'h3, 4'h7);
    clk_512Hz_in = 1'b0;
    readcnt(20'h0000A, "collide_unmapped_cnt");
    rd(4'h8, 4'h1, "collide_ctrl");

    // Gating: stopped timer ignores ticks; unmapped reads/writes are inert
    wr(4'h8, 4'h0);
    for (int i = 0; i < 10; i++) tick();
    readcnt(20'h0000A, "gated_cnt");
    rd(4'hE, 4'h0, "unmapped_rd");
    wr(4'h3, 4'hF);
    rd(4'h8, 4'h0, "unmapped_wr_ctrl");
    readcnt(20'h0000A, "unmapped_wr_cnt");

    // Simultaneous read and write returns pre-write value
    bus.read_in = 1'b1;
    wr(4'h8, 4'h1);
    bus.read_in = 1'b0;
    chk("rw_prewrite", {16'h0, bus.data_o}, 20'h0);
    rd(4'h8, 4'h1, "rw_postwrite");

    // Reset mid-run with IRQ asserted
    wr(4'h8, 4'h0);
    wcnt(20'h0);
    wr(4'h8, 4'h3);
    tick();
    cyc();
    rd(4'h8, 4'h7, "pre_reset_ctrl");
    chk("pre_reset_irq", {19'h0, irq_o}, 20'h1);
    #3 reset_n_in = 1'b0;
    #1;
    chk("midreset_data", {16'h0, bus.data_o}, 20'h0);
    chk("midreset_irq", {19'h0, irq_o}, 20'h0);
    #3 reset_n_in = 1'b1;
    cyc();
    rd(4'h8, 4'h0, "post_reset_ctrl");
    readcnt(20'h0, "post_reset_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
